// File: rtl/regread.sv
// Register-read stage: owns the integer register file and feeds operands to EX.
// Optional same-cycle writeback bypass: define REGREAD_WB_BYPASS_EN.
package regread_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int IDX_W    = $clog2(NUM_REGS);

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } reg_ref_t;

   typedef struct packed {
      reg_ref_t rs1;
      reg_ref_t rs2;
      reg_ref_t rd;
   } decode_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] cause;
   } except_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      decode_t         decode;
      except_t         except;
   } issued_instr_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      decode_t         decode;
      except_t         except;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
   } operand_instr_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  data;
   } int_arch_reg_wb_t;

endpackage

module regread
   import regread_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_stall,
   input  issued_instr_t    i_instr,
   output logic             o_stall,
   output operand_instr_t   o_instr,
   input  int_arch_reg_wb_t i_int_reg_wb
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] REPLAY = 1'b1;

   logic [XLEN-1:0] regs [NUM_REGS];
   logic [0:0]      state;
   logic [XLEN-1:0] rs1_raw;
   logic [XLEN-1:0] rs2_raw;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            wb_live;
   logic            hit1;
   logic            hit2;
   logic            hazard;

   assign wb_live = i_int_reg_wb.valid & (i_int_reg_wb.idx != '0);
   assign hit1 = wb_live & i_instr.decode.rs1.valid
               & (i_instr.decode.rs1.idx == i_int_reg_wb.idx);
   assign hit2 = wb_live & i_instr.decode.rs2.valid
               & (i_instr.decode.rs2.idx == i_int_reg_wb.idx);

   always_comb begin
      rs1_raw = '0;
      rs2_raw = '0;
      if (i_instr.decode.rs1.valid && i_instr.decode.rs1.idx != '0)
         rs1_raw = regs[i_instr.decode.rs1.idx];
      if (i_instr.decode.rs2.valid && i_instr.decode.rs2.idx != '0)
         rs2_raw = regs[i_instr.decode.rs2.idx];
   end

`ifdef REGREAD_WB_BYPASS_EN
   assign rs1_data = hit1 ? i_int_reg_wb.data : rs1_raw;
   assign rs2_data = hit2 ? i_int_reg_wb.data : rs2_raw;
   assign hazard   = 1'b0;
`else
   assign rs1_data = rs1_raw;
   assign rs2_data = rs2_raw;
   assign hazard   = i_instr.valid & (hit1 | hit2);
`endif

   // A hazard seen in REPLAY is handled exactly like one in IDLE.
   assign o_stall = i_stall | (i_rst_n & hazard);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wb_live) begin
         regs[i_int_reg_wb.idx] <= i_int_reg_wb.data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_instr <= '0;
         state   <= IDLE;
      end else if (i_flush) begin
         o_instr <= '0;
         state   <= IDLE;
      end else if (!i_stall) begin
         unique case (state)
            IDLE: begin
               if (hazard) begin
                  o_instr <= '0;
                  state   <= REPLAY;
               end else begin
                  o_instr.valid    <= i_instr.valid;
                  o_instr.pc       <= i_instr.pc;
                  o_instr.decode   <= i_instr.decode;
                  o_instr.except   <= i_instr.except;
                  o_instr.rs1_data <= rs1_data;
                  o_instr.rs2_data <= rs2_data;
               end
            end
            REPLAY: begin
               if (hazard) begin
                  o_instr <= '0;
               end else begin
                  o_instr.valid    <= i_instr.valid;
                  o_instr.pc       <= i_instr.pc;
                  o_instr.decode   <= i_instr.decode;
                  o_instr.except   <= i_instr.except;
                  o_instr.rs1_data <= rs1_data;
                  o_instr.rs2_data <= rs2_data;
                  state            <= IDLE;
               end
            end
            default: begin
               o_instr <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regread.sv
// Scoreboard bench for regread: random + directed traffic against an
// architectural model of the register file and issue protocol.
module tb_regread;
   import regread_pkg::*;

`ifdef REGREAD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef enum {EV_NONE, EV_RST, EV_FLUSH, EV_HOLD, EV_LOAD} ev_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             stall;
   issued_instr_t    instr;
   int_arch_reg_wb_t wb;
   logic             o_stall;
   operand_instr_t   o_instr;

   logic [XLEN-1:0]  mregs [NUM_REGS];
   operand_instr_t   expq [$];
   operand_instr_t   last_exp = '0;
   ev_t              ev = EV_NONE;
   bit               accepted;
   int               n_cmp = 0;
   int               n_bad = 0;

   regread dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_flush      (flush),
      .i_stall      (stall),
      .i_instr      (instr),
      .o_stall      (o_stall),
      .o_instr      (o_instr),
      .i_int_reg_wb (wb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_instr(input string name, input operand_instr_t e);
      if (!e.valid)
         check({name, ".valid"}, 128'(o_instr.valid), 128'(1'b0));
      else
         check(name, 128'(o_instr), 128'(e));
   endtask

   // Operands reflect every write up to and including the accepting edge.
   function automatic logic [XLEN-1:0] opnd(input reg_ref_t r);
      if (!r.valid || r.idx == '0) return '0;
      if (wb.valid && wb.idx == r.idx) return wb.data;
      return mregs[r.idx];
   endfunction

   function automatic bit hazard_now();
      bit h1, h2;
      if (BYP || !rst_n || !instr.valid || !wb.valid || wb.idx == '0)
         return 1'b0;
      h1 = instr.decode.rs1.valid && instr.decode.rs1.idx == wb.idx;
      h2 = instr.decode.rs2.valid && instr.decode.rs2.idx == wb.idx;
      return h1 || h2;
   endfunction

   task automatic step();
      bit             es;
      operand_instr_t op;
      es = stall || hazard_now();
      #1 check("o_stall", 128'(o_stall), 128'(es));
      accepted = 1'b0;
      @(posedge clk);
      if (!rst_n) begin
         foreach (mregs[i]) mregs[i] = '0;
         expq.delete();
         ev = EV_RST;
      end else begin
         if (flush) begin
            ev = EV_FLUSH;
         end else if (stall) begin
            ev = EV_HOLD;
         end else begin
            ev = EV_LOAD;
            op = '0;
            if (!es && instr.valid) begin
               op.valid    = 1'b1;
               op.pc       = instr.pc;
               op.decode   = instr.decode;
               op.except   = instr.except;
               op.rs1_data = opnd(instr.decode.rs1);
               op.rs2_data = opnd(instr.decode.rs2);
            end
            accepted = !es;
            expq.push_back(op);
         end
         if (wb.valid && wb.idx != '0) mregs[wb.idx] = wb.data;
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      operand_instr_t e;
      case (ev)
         EV_LOAD: begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL load: DUT output with empty queue at %0t", $time);
            end else begin
               e = expq.pop_front();
               last_exp = e;
               cmp_instr("load", e);
            end
         end
         EV_HOLD: cmp_instr("hold", last_exp);
         EV_FLUSH: begin
            last_exp = '0;
            check("flush", 128'(o_instr), 128'(0));
         end
         EV_RST: begin
            last_exp = '0;
            check("reset", 128'(o_instr), 128'(0));
         end
         default: ;
      endcase
   end

   function automatic issued_instr_t mk(input logic [4:0] r1, input logic v1,
                                        input logic [4:0] r2, input logic v2);
      issued_instr_t t;
      t.valid             = 1'b1;
      t.pc                = $urandom;
      t.decode.rs1.valid  = v1;
      t.decode.rs1.idx    = r1;
      t.decode.rs2.valid  = v2;
      t.decode.rs2.idx    = r2;
      t.decode.rd.valid   = 1'b1;
      t.decode.rd.idx     = 5'($urandom_range(1, 31));
      t.except.valid      = ($urandom_range(0, 7) == 0);
      t.except.cause      = 4'($urandom);
      return t;
   endfunction

   function automatic int_arch_reg_wb_t mkwb(input logic [4:0] idx,
                                             input logic [31:0] d);
      int_arch_reg_wb_t w;
      w.valid = 1'b1;
      w.idx   = idx;
      w.data  = d;
      return w;
   endfunction

   task automatic issue(input issued_instr_t t);
      instr = t;
      for (int i = 0; i < 20; i++) begin
         step();
         wb = '0;
         if (accepted) break;
      end
      if (!accepted) begin
         n_cmp++;
         n_bad++;
         $display("FAIL issue_timeout: accepted=0 required=1");
      end
      instr = '0;
   endtask

   initial begin
      bit               need_new;
      issued_instr_t    t;
      rst_n = 1'b0;
      flush = 1'b0;
      stall = 1'b0;
      instr = '0;
      wb    = '0;
      step();
      step();
      rst_n = 1'b1;

      issue(mk(5'd5, 1'b1, 5'd0, 1'b1));

      wb = mkwb(5'd7, 32'hDEADBEEF);
      step();
      wb = '0;
      issue(mk(5'd7, 1'b1, 5'd7, 1'b1));

      wb = mkwb(5'd0, 32'd1234);
      step();
      wb = '0;
      issue(mk(5'd0, 1'b1, 5'd0, 1'b1));

      wb = mkwb(5'd3, 32'h55);
      issue(mk(5'd2, 1'b0, 5'd3, 1'b1));
      step();

      issue(mk(5'd1, 1'b1, 5'd7, 1'b1));
      stall = 1'b1;
      wb = mkwb(5'd1, 32'hA5A5_0001);
      step();
      wb = '0;
      step();
      step();
      stall = 1'b0;
      issue(mk(5'd1, 1'b1, 5'd0, 1'b0));

      issue(mk(5'd7, 1'b1, 5'd1, 1'b1));
      stall = 1'b1;
      flush = 1'b1;
      step();
      stall = 1'b0;
      flush = 1'b0;

      wb = mkwb(5'd4, 32'h4444);
      instr = mk(5'd4, 1'b1, 5'd0, 1'b0);
      step();
      wb = '0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      instr = '0;
      step();
      step();

      wb = mkwb(5'd9, 32'd77);
      instr = mk(5'd9, 1'b1, 5'd0, 1'b0);
      step();
      wb = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      issue(mk(5'd9, 1'b1, 5'd9, 1'b1));

      need_new = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (need_new) begin
            t = mk(5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom));
            t.valid = ($urandom_range(0, 4) != 0);
            instr = t;
         end
         if ($urandom_range(0, 1) == 0)
            wb = '0;
         else if ($urandom_range(0, 2) == 0)
            wb = mkwb(instr.decode.rs1.idx, $urandom);
         else
            wb = mkwb(5'($urandom_range(0, 7)), $urandom);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 29) == 0);
         rst_n = ($urandom_range(0, 499) != 0);
         step();
         need_new = accepted || flush || !rst_n;
      end

      rst_n = 1'b1;
      flush = 1'b0;
      stall = 1'b0;
      wb    = '0;
      instr = '0;
      step();
      step();
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
